// File: rtl/shift_seq_pkg.sv
// Shared types and operand-2 classification for the shift sequencer.
package shift_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RS_REQ,
    RS_DATA,
    EXEC,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    IMM,
    SHIMM,
    REG
  } op2_kind_t;

  localparam int unsigned RS_FIELD_LSB = 8;
  localparam int unsigned INSTR_W      = 26;

  // Bit 25 marks an immediate operand; otherwise bit 4 selects a register-specified shift.
  function automatic op2_kind_t classify(input logic [25:0] instr);
    if (instr[25]) begin
      return IMM;
    end else if (instr[4]) begin
      return REG;
    end else begin
      return SHIMM;
    end
  endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Schedules operand delivery to the barrel shifter: fetches Rs over a shared read port when
// needed, drives the shifter, and holds its result until the execute stage takes it.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [DATA_W-1:0]  in_rm,
  output logic               rs_req,
  output logic [RADDR_W-1:0] rs_addr,
  input  logic               rs_gnt,
  input  logic [DATA_W-1:0]  rs_data,
  output logic [INSTR_W-1:0] sh_instr,
  output logic [DATA_W-1:0]  sh_rm,
  output logic [DATA_W-1:0]  sh_rs,
  input  logic [DATA_W-1:0]  sh_rd,
  input  logic [3:0]         sh_flags,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [3:0]         out_flags,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  rm_q;
  logic [DATA_W-1:0]  rs_q;
  logic [DATA_W-1:0]  result_q;
  logic [3:0]         flags_q;

  logic      accept;
  logic      cap_rs;
  logic      cap_res;
  op2_kind_t in_kind;

  assign in_kind = classify(in_instr);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cap_rs  = 1'b0;
    cap_res = 1'b0;
    case (state_q)
      IDLE:    accept = in_valid;
      RS_REQ:  if (rs_gnt) state_d = RS_DATA;
      RS_DATA: begin
        cap_rs  = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        cap_res = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          accept  = in_valid;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = (in_kind == REG) ? RS_REQ : EXEC;
    end
    // Abort wins over everything, including a grant arriving this cycle.
    if (flush) begin
      state_d = IDLE;
      accept  = 1'b0;
      cap_rs  = 1'b0;
      cap_res = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      rm_q     <= '0;
      rs_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q <= in_instr;
        rm_q    <= in_rm;
        rs_q    <= '0;
      end
      if (cap_rs) begin
        rs_q <= rs_data;
      end
      if (cap_res) begin
        result_q <= sh_rd;
        flags_q  <= sh_flags;
      end
    end
  end

  assign in_ready   = ~flush & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign busy       = (state_q != IDLE);
  // Moore request, never a function of rs_gnt.
  assign rs_req     = (state_q == RS_REQ) & ~flush;
  assign rs_addr    = instr_q[RS_FIELD_LSB +: RADDR_W];
  assign sh_instr   = instr_q;
  assign sh_rm      = rm_q;
  assign sh_rs      = rs_q;
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_flags  = flags_q;

endmodule
